nios2_debug_ocimem_access: RTL and testbench
============================================

// Module: nios2_debug_ocimem_access
// PURPOSE
//  Consumer of the debug-slave sysclk strobes (take_action_ocimem_a/b, take_no_action_ocimem_a, jdo).
//  Owns the 2^AW x 32 on-chip debug monitor RAM. Executes host JTAG read/write requests and returns read data on MonDReg.
//  Shares the RAM with the CPU debug Avalon slave port; JTAG has priority.
// PARAMETERS
//  AW  8  RAM word-address width; depth = 2^AW words
// PORTS
//  clk                      in   1   system clock
//  reset                    in   1   async active-high reset
//  jdo                      in   38  JTAG data latched by the debug slave (sysclk domain)
//  take_action_ocimem_a     in   1   pulse: load address = jdo[AW+1:2]; start a read if jdo[35]
//  take_no_action_ocimem_a  in   1   pulse: read at MonAReg, then MonAReg+1
//  take_action_ocimem_b     in   1   pulse: write jdo[34:3] at MonAReg, then MonAReg+1
//  avs_address              in   AW  CPU word address
//  avs_read / avs_write     in   1   CPU request; held until waitrequest is low
//  avs_writedata            in   32  CPU write data
//  avs_byteenable           in   4   CPU byte lanes
//  avs_readdata             out  32  CPU read data; valid when avs_read=1 and waitrequest=0
//  avs_waitrequest          out  1   stall for the CPU port
//  MonDReg                  out  32  last JTAG read data, sampled by the tck side
//  MonAReg                  out  AW  current JTAG word address
//  jtag_busy                out  1   JTAG operation in progress
//  jtag_overrun             out  1   sticky: a strobe arrived while jtag_busy
// BEHAVIOUR
//  Reset: all outputs 0 except avs_waitrequest=1. FSM goes to IDLE. RAM contents are not reset.
//  FSM states: IDLE, J_RD, J_CAP, J_WR, A_RD, A_CAP, A_WR.
//  RAM: single-port, synchronous read, 1-cycle latency. Each write cycle is one RAM access.
//  IDLE priority, checked in order:
//   1. JTAG strobe
//   2. avs_read -> A_RD
//   3. avs_write -> A_WR
//   4. otherwise stay in IDLE
//  JTAG strobe handling:
//   - take_action_ocimem_a: load MonAReg. Go to J_RD if jdo[35]=1, else stay in IDLE.
//   - take_no_action_ocimem_a: go to J_RD.
//   - take_action_ocimem_b: go to J_WR.
//  If two strobes arrive in the same cycle, priority is take_action_ocimem_a > take_action_ocimem_b > take_no_action_ocimem_a.
//   - The lower-priority strobe is dropped and sets jtag_overrun.
//  J_RD: drive RAM address = MonAReg -> J_CAP.
//  J_CAP: MonDReg <= RAM q. MonAReg <= MonAReg+1 (mod 2^AW, 2^AW-1 wraps to 0). -> IDLE.
//  J_WR: RAM[MonAReg] <= jdo[34:3], all byte lanes. MonAReg <= MonAReg+1 (wraps). -> IDLE.
//  jtag_busy = 1 in J_RD, J_CAP and J_WR, and in the cycle a strobe is accepted.
//  A strobe while jtag_busy=1 is dropped and sets jtag_overrun.
//  jtag_overrun is cleared only by an accepted take_action_ocimem_a.
//  A_RD: drive RAM address = avs_address -> A_CAP.
//  A_CAP: avs_readdata <= q. avs_waitrequest=0 for exactly this cycle. -> IDLE.
//  A_WR: byte-enabled write. avs_waitrequest=0 this cycle. -> IDLE.
//  avs_waitrequest is 1 in all other states and cycles. A CPU read therefore takes at least 3 cycles and a write at least 2.
//  A JTAG strobe arriving during A_* does not abort the CPU access.
//   - It is latched as pending (one deep) and serviced before any new CPU request in IDLE.
//  avs_read and avs_write both asserted in the same cycle: treat as a read. The write is then taken in a later IDLE.
//  reset asserted mid-operation: FSM goes to IDLE. Any partial CPU access is abandoned, with waitrequest=1.
//   A RAM write issued in the same cycle may or may not complete.
// TESTING
//  T1 address load: take_action_ocimem_a with jdo[AW+1:2]=0x10, jdo[35]=0 -> MonAReg=0x10, no RAM access, jtag_busy stays 0 after 1 cycle.
//  T2 JTAG write/read: write 0xDEADBEEF at 0x10, reload address 0x10 with jdo[35]=1 -> MonDReg=0xDEADBEEF 2 cycles after the strobe, MonAReg=0x11.
//  T3 wrap: MonAReg=0xFF (AW=8), take_action_ocimem_b -> RAM[0xFF] is written and MonAReg=0x00.
//  T4 arbitration: CPU avs_read held at 0x10; take_no_action_ocimem_a in the same cycle -> JTAG read completes first. CPU then gets 0xDEADBEEF with waitrequest low for exactly 1 cycle.
//  T5 byteenable: CPU write 0x11223344 with be=4'b0101 over 0xDEADBEEF -> JTAG read returns 0xDE22BE44.
//  T6 overrun: two take_no_action_ocimem_a pulses 1 cycle apart -> jtag_overrun=1. The next take_action_ocimem_a clears it. Async reset mid-A_RD -> waitrequest=1 and FSM in IDLE.

Source files
------------

// File: rtl/nios2_debug_ocimem_access.sv
`default_nettype none
// ============================================================================
//  Module   : nios2_debug_ocimem_access
//  Purpose  : Debug monitor RAM shared between JTAG strobes and a CPU Avalon
//             slave; JTAG requests take priority over CPU accesses.
//  Revision : 1.0 - initial release
// ============================================================================
module nios2_debug_ocimem_access #(
  parameter int AW = 8
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic [37:0]   i_jdo,
  input  logic          i_take_action_ocimem_a,
  input  logic          i_take_no_action_ocimem_a,
  input  logic          i_take_action_ocimem_b,
  input  logic [AW-1:0] i_avs_address,
  input  logic          i_avs_read,
  input  logic          i_avs_write,
  input  logic [31:0]   i_avs_writedata,
  input  logic [3:0]    i_avs_byteenable,
  output logic [31:0]   o_avs_readdata,
  output logic          o_avs_waitrequest,
  output logic [31:0]   o_MonDReg,
  output logic [AW-1:0] o_MonAReg,
  output logic          o_jtag_busy,
  output logic          o_jtag_overrun
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_J_RD  = 3'd1,
    S_J_CAP = 3'd2,
    S_J_WR  = 3'd3,
    S_A_RD  = 3'd4,
    S_A_CAP = 3'd5,
    S_A_WR  = 3'd6
  } state_t;

  localparam logic [1:0] c_KIND_A  = 2'd0;
  localparam logic [1:0] c_KIND_B  = 2'd1;
  localparam logic [1:0] c_KIND_NA = 2'd2;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_mem [2**AW];
  logic [31:0]   r_q;
  logic [31:0]   r_mon_d;
  logic [31:0]   r_wdata;
  logic [AW-1:0] r_mon_a;
  logic          r_overrun;
  logic          r_pend_valid;
  logic [1:0]    r_pend_kind;
  logic [33:0]   r_pend_jdo;

  logic          w_live_any;
  logic          w_live_multi;
  logic [1:0]    w_live_kind;
  logic          w_j_state;
  logic          w_a_state;
  logic          w_accept;
  logic          w_drop;
  logic [1:0]    w_kind;
  logic [33:0]   w_src_jdo;
  logic          w_ram_re;
  logic          w_ram_we;
  logic [AW-1:0] w_ram_addr;
  logic [3:0]    w_ram_be;
  logic [31:0]   w_ram_wdata;
  logic          w_unused_jdo;

  assign w_unused_jdo = ^{i_jdo[37:36], i_jdo[1:0]};

  assign w_live_any   = i_take_action_ocimem_a | i_take_action_ocimem_b | i_take_no_action_ocimem_a;
  assign w_live_multi = (i_take_action_ocimem_a & (i_take_action_ocimem_b | i_take_no_action_ocimem_a))
                      | (i_take_action_ocimem_b & i_take_no_action_ocimem_a);

  always_comb begin
    w_live_kind = c_KIND_NA;
    if (i_take_action_ocimem_a)      w_live_kind = c_KIND_A;
    else if (i_take_action_ocimem_b) w_live_kind = c_KIND_B;
  end

  assign w_j_state = (r_state == S_J_RD) || (r_state == S_J_CAP) || (r_state == S_J_WR);
  assign w_a_state = (r_state == S_A_RD) || (r_state == S_A_CAP) || (r_state == S_A_WR);

  // A strobe parked during a CPU access is served before any live strobe.
  assign w_accept  = (r_state == S_IDLE) && (r_pend_valid || w_live_any);
  assign w_kind    = r_pend_valid ? r_pend_kind : w_live_kind;
  assign w_src_jdo = r_pend_valid ? r_pend_jdo  : i_jdo[35:2];
  assign w_drop    = w_live_multi | (w_live_any & (w_j_state | r_pend_valid));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (w_kind)
            c_KIND_A: w_next = w_src_jdo[33] ? S_J_RD : S_IDLE;
            c_KIND_B: w_next = S_J_WR;
            default:  w_next = S_J_RD;
          endcase
        end else if (i_avs_read) begin
          w_next = S_A_RD;
        end else if (i_avs_write) begin
          w_next = S_A_WR;
        end
      end
      S_J_RD:  w_next = S_J_CAP;
      S_J_CAP: w_next = S_IDLE;
      S_J_WR:  w_next = S_IDLE;
      S_A_RD:  w_next = S_A_CAP;
      S_A_CAP: w_next = S_IDLE;
      S_A_WR:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_ram_re    = (r_state == S_J_RD) || (r_state == S_A_RD);
  assign w_ram_we    = (r_state == S_J_WR) || (r_state == S_A_WR);
  assign w_ram_addr  = w_j_state ? r_mon_a : i_avs_address;
  assign w_ram_be    = (r_state == S_J_WR) ? 4'hF : i_avs_byteenable;
  assign w_ram_wdata = (r_state == S_J_WR) ? r_wdata : i_avs_writedata;

  always_ff @(posedge i_clk) begin
    if (w_ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_ram_be[i]) r_mem[w_ram_addr][8*i +: 8] <= w_ram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_q          <= '0;
      r_mon_d      <= '0;
      r_mon_a      <= '0;
      r_wdata      <= '0;
      r_overrun    <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_kind  <= c_KIND_NA;
      r_pend_jdo   <= '0;
    end else begin
      if (w_ram_re) r_q <= r_mem[w_ram_addr];

      if (w_drop)                             r_overrun <= 1'b1;
      else if (w_accept && w_kind == c_KIND_A) r_overrun <= 1'b0;

      // w_src_jdo holds jdo[35:2]: data jdo[34:3] -> [32:1], address jdo[AW+1:2] -> [AW-1:0]
      if (w_accept) begin
        r_wdata <= w_src_jdo[32:1];
        if (w_kind == c_KIND_A) r_mon_a <= w_src_jdo[AW-1:0];
      end
      if ((r_state == S_J_CAP) || (r_state == S_J_WR)) r_mon_a <= r_mon_a + AW'(1);
      if (r_state == S_J_CAP) r_mon_d <= r_q;

      if ((r_state == S_IDLE) && r_pend_valid) begin
        r_pend_valid <= 1'b0;
      end else if (w_a_state && !r_pend_valid && w_live_any) begin
        r_pend_valid <= 1'b1;
        r_pend_kind  <= w_live_kind;
        r_pend_jdo   <= i_jdo[35:2];
      end
    end
  end

  assign o_avs_readdata    = r_q;
  assign o_avs_waitrequest = !((r_state == S_A_CAP) || (r_state == S_A_WR));
  assign o_MonDReg         = r_mon_d;
  assign o_MonAReg         = r_mon_a;
  assign o_jtag_busy       = w_j_state | w_accept;
  assign o_jtag_overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_nios2_debug_ocimem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios2_debug_ocimem_access
//  Purpose  : Directed and randomized checks of the debug monitor RAM block
//             against a transaction-level memory model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nios2_debug_ocimem_access;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [37:0]   jdo;
  logic          tka, tkna, tkb;
  logic [AW-1:0] avs_address;
  logic          avs_read, avs_write;
  logic [31:0]   avs_writedata;
  logic [3:0]    avs_byteenable;
  logic [31:0]   avs_readdata;
  logic          avs_waitrequest;
  logic [31:0]   mon_d;
  logic [AW-1:0] mon_a;
  logic          busy, overrun;

  nios2_debug_ocimem_access #(.AW(AW)) dut (
    .i_clk                     (clk),
    .i_reset                   (reset),
    .i_jdo                     (jdo),
    .i_take_action_ocimem_a    (tka),
    .i_take_no_action_ocimem_a (tkna),
    .i_take_action_ocimem_b    (tkb),
    .i_avs_address             (avs_address),
    .i_avs_read                (avs_read),
    .i_avs_write               (avs_write),
    .i_avs_writedata           (avs_writedata),
    .i_avs_byteenable          (avs_byteenable),
    .o_avs_readdata            (avs_readdata),
    .o_avs_waitrequest         (avs_waitrequest),
    .o_MonDReg                 (mon_d),
    .o_MonAReg                 (mon_a),
    .o_jtag_busy               (busy),
    .o_jtag_overrun            (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Transaction-level reference state
  logic [31:0]   m_mem [2**AW];
  logic [AW-1:0] m_a;
  logic [31:0]   m_d;
  logic          m_ovr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return AW'((int'(a) + 1) % (2**AW));
  endfunction

  function automatic logic [37:0] rand_jdo();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[37:0];
  endfunction

  function automatic logic [37:0] ld_jdo(input logic [AW-1:0] addr, input logic rd);
    logic [37:0] j;
    j = rand_jdo();
    j[35] = rd;
    j[AW+1:2] = addr;
    return j;
  endfunction

  function automatic logic [37:0] wr_jdo(input logic [31:0] data);
    logic [37:0] j;
    j = rand_jdo();
    j[34:3] = data;
    return j;
  endfunction

  // kind: 0 = take_action_a, 1 = take_action_b, 2 = take_no_action_a
  task automatic strobe(input int kind, input logic [37:0] d);
    jdo  = d;
    tka  = (kind == 0);
    tkb  = (kind == 1);
    tkna = (kind == 2);
    tick();
    tka = 1'b0; tkb = 1'b0; tkna = 1'b0;
    #1;
  endtask

  task automatic wait_jtag_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_busy_done"}, busy, 0);
  endtask

  task automatic jtag_load(input logic [AW-1:0] addr, input logic rd);
    strobe(0, ld_jdo(addr, rd));
    m_a   = addr;
    m_ovr = 1'b0;
    if (rd) begin
      m_d = m_mem[m_a];
      m_a = next_addr(m_a);
    end
    wait_jtag_idle("load");
    check("load_areg", mon_a, m_a);
    check("load_ovr", overrun, m_ovr);
    if (rd) check("load_dreg", mon_d, m_d);
  endtask

  task automatic jtag_read();
    strobe(2, rand_jdo());
    m_d = m_mem[m_a];
    m_a = next_addr(m_a);
    wait_jtag_idle("jrd");
    check("jrd_dreg", mon_d, m_d);
    check("jrd_areg", mon_a, m_a);
  endtask

  task automatic jtag_write(input logic [31:0] data, input bit do_check);
    strobe(1, wr_jdo(data));
    m_mem[m_a] = data;
    m_a = next_addr(m_a);
    wait_jtag_idle("jwr");
    if (do_check) check("jwr_areg", mon_a, m_a);
  endtask

  task automatic cpu_read(input logic [AW-1:0] addr);
    int n;
    avs_address = addr;
    avs_read    = 1'b1;
    n = 0;
    while (avs_waitrequest && n < 20) begin
      tick();
      n++;
    end
    check("crd_wait_low", avs_waitrequest, 0);
    check("crd_latency", n, 2);
    check("crd_data", avs_readdata, m_mem[addr]);
    avs_read = 1'b0;
    tick();
  endtask

  task automatic cpu_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] be);
    int n;
    logic [31:0] mask;
    avs_address = addr; avs_writedata = data; avs_byteenable = be;
    avs_write = 1'b1;
    n = 0;
    while (avs_waitrequest && n < 20) begin
      tick();
      n++;
    end
    check("cwr_wait_low", avs_waitrequest, 0);
    check("cwr_latency", n, 1);
    avs_write = 1'b0;
    tick();
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    m_mem[addr] = (m_mem[addr] & ~mask) | (data & mask);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] exp_d;
    reset = 1'b1; jdo = '0; tka = 1'b0; tkb = 1'b0; tkna = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
    avs_writedata = '0; avs_byteenable = '0;
    m_a = '0; m_d = '0; m_ovr = 1'b0;
    tick(); tick();
    check("rst_waitreq", avs_waitrequest, 1);
    check("rst_readdata", avs_readdata, 0);
    check("rst_dreg", mon_d, 0);
    check("rst_areg", mon_a, 0);
    check("rst_busy", busy, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    tick();

    // Fill the whole RAM so the model never holds unknown words
    jtag_load('0, 1'b0);
    for (int i = 0; i < 2**AW; i++) jtag_write($urandom, 1'b0);
    check("fill_wrap_areg", mon_a, 0);

    // T1: address load without read
    jdo = ld_jdo(8'h10, 1'b0);
    tka = 1'b1;
    #1;
    check("t1_busy_accept", busy, 1);
    tick();
    tka = 1'b0;
    #1;
    check("t1_busy_after", busy, 0);
    check("t1_areg", mon_a, 8'h10);
    m_a = 8'h10;

    // T2: write then reload-with-read, fixed latency
    jtag_write(32'hDEADBEEF, 1'b1);
    strobe(0, ld_jdo(8'h10, 1'b1));
    tick(); tick();
    check("t2_dreg", mon_d, 32'hDEADBEEF);
    check("t2_areg", mon_a, 8'h11);
    m_a = 8'h11; m_d = 32'hDEADBEEF;
    tick();

    // T3: address wrap on write
    jtag_load(8'hFF, 1'b0);
    jtag_write(32'hCAFEF00D, 1'b1);
    check("t3_wrap", mon_a, 8'h00);
    jtag_load(8'hFF, 1'b1);
    check("t3_data", mon_d, 32'hCAFEF00D);

    // T4: CPU read and JTAG read in the same cycle, JTAG wins
    avs_address = 8'h10; avs_read = 1'b1;
    jdo = rand_jdo(); tkna = 1'b1;
    exp_d = m_mem[m_a];
    m_d = exp_d; m_a = next_addr(m_a);
    tick();
    tkna = 1'b0;
    n = 1;
    while (avs_waitrequest && n < 20) begin
      tick();
      n++;
    end
    check("t4_latency", n, 5);
    check("t4_jtag_first", mon_d, exp_d);
    check("t4_cpu_data", avs_readdata, 32'hDEADBEEF);
    avs_read = 1'b0;
    tick();
    check("t4_wait_one_cycle", avs_waitrequest, 1);
    check("t4_areg", mon_a, m_a);

    // T5: byte-enabled CPU write
    cpu_write(8'h10, 32'h11223344, 4'b0101);
    jtag_load(8'h10, 1'b1);
    check("t5_merge", mon_d, 32'hDE22BE44);

    // T6: back-to-back strobes overrun, cleared by a load
    strobe(2, rand_jdo());
    strobe(2, rand_jdo());
    m_d = m_mem[m_a]; m_a = next_addr(m_a);
    wait_jtag_idle("t6");
    check("t6_ovr_set", overrun, 1);
    check("t6_single_read", mon_a, m_a);
    check("t6_dreg", mon_d, m_d);
    jtag_load(8'h20, 1'b0);
    check("t6_ovr_clear", overrun, 0);

    // Simultaneous write and read strobes: write wins, read dropped
    jdo = wr_jdo(32'h0BADF00D); tkb = 1'b1; tkna = 1'b1;
    tick();
    tkb = 1'b0; tkna = 1'b0;
    #1;
    m_mem[m_a] = 32'h0BADF00D; m_a = next_addr(m_a);
    wait_jtag_idle("dual");
    check("dual_ovr", overrun, 1);
    check("dual_areg", mon_a, m_a);
    jtag_load(8'h20, 1'b1);
    check("dual_data", mon_d, 32'h0BADF00D);

    // Strobe arriving during a CPU read is held and served afterwards
    avs_address = 8'h05; avs_read = 1'b1;
    tick();
    jdo = rand_jdo(); tkna = 1'b1;
    tick();
    tkna = 1'b0;
    #1;
    check("pend_cpu_wait", avs_waitrequest, 0);
    check("pend_cpu_data", avs_readdata, m_mem[8'h05]);
    avs_read = 1'b0;
    m_d = m_mem[m_a]; m_a = next_addr(m_a);
    tick();
    check("pend_busy", busy, 1);
    wait_jtag_idle("pend");
    check("pend_dreg", mon_d, m_d);
    check("pend_areg", mon_a, m_a);
    check("pend_ovr", overrun, 0);

    // Randomized mix
    for (int k = 0; k < 80; k++) begin
      case ($urandom_range(0, 4))
        0: jtag_load(AW'($urandom_range(0, 2**AW - 1)), 1'($urandom_range(0, 1)));
        1: jtag_read();
        2: jtag_write($urandom, 1'b1);
        3: cpu_read(AW'($urandom_range(0, 2**AW - 1)));
        default: cpu_write(AW'($urandom_range(0, 2**AW - 1)), $urandom, 4'($urandom_range(0, 15)));
      endcase
    end

    // Async reset in the middle of a CPU read
    avs_address = 8'h33; avs_read = 1'b1;
    tick();
    check("rstmid_in_ard", avs_waitrequest, 1);
    #2;
    reset = 1'b1;
    #1;
    check("rstmid_waitreq", avs_waitrequest, 1);
    check("rstmid_busy", busy, 0);
    check("rstmid_areg", mon_a, 0);
    avs_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    m_a = '0; m_d = '0; m_ovr = 1'b0;
    check("rstmid_idle_wait", avs_waitrequest, 1);
    check("rstmid_dreg", mon_d, 0);
    cpu_read(8'h33);
    jtag_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
